// File: rtl/lsu_bus_ctrl.sv
// ============================================================================
// Module   : lsu_bus_ctrl
// Purpose  : Load/store bus controller. Issues one req/ack transaction per
//            load/store, stalls the core until it completes, generates byte
//            enables and lane-replicated store data, and returns load data
//            right-aligned with zeroed upper bits.
// Options  : LSU_MISALIGN_TRAP_EN - trap misaligned half/word accesses
//            instead of issuing them on the bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} RV32I_INSTRUCTION_MNEMONIC_t;
endpackage

module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req_i,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [31:0]                 mem_addr_i,
  input  logic [31:0]                 mem_wdata_i,
  output logic                        stall_o,
  output logic [31:0]                 bus_rddata,
  output logic                        bus_err_o,
  output logic                        misalign_o,
  output logic                        bus_req_o,
  output logic                        bus_we_o,
  output logic [31:0]                 bus_addr_o,
  output logic [3:0]                  bus_be_o,
  output logic [31:0]                 bus_wdata_o,
  input  logic                        bus_ack_i,
  input  logic [31:0]                 bus_rdata_i
);

  localparam int              CNT_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      C_SZ_B     = 2'd0;
  localparam logic [1:0]      C_SZ_H     = 2'd1;
  localparam logic [1:0]      C_SZ_W     = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [29:0]      r_waddr;
  logic [1:0]       r_lane, r_size;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata, r_rddata;
  logic             r_mis;

  logic             w_we, w_misalign, w_capture, w_timeout;
  logic [1:0]       w_size;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_load, w_mask;
  logic [4:0]       w_shamt;

  // Decode the mnemonic into direction/size and build enables and store data
  always_comb begin
    w_we       = 1'b0;
    w_size     = C_SZ_W;
    w_be       = 4'b1111;
    w_wdata    = mem_wdata_i;
    w_misalign = 1'b0;
    case (mnemonic)
      LB, LBU: w_size = C_SZ_B;
      LH, LHU: w_size = C_SZ_H;
      SB:      begin w_size = C_SZ_B; w_we = 1'b1; end
      SH:      begin w_size = C_SZ_H; w_we = 1'b1; end
      SW:      begin w_size = C_SZ_W; w_we = 1'b1; end
      default: w_size = C_SZ_W;
    endcase
    if (w_we) begin
      case (w_size)
        C_SZ_B:  begin w_be = 4'b0001 << mem_addr_i[1:0];       w_wdata = {4{mem_wdata_i[7:0]}};  end
        C_SZ_H:  begin w_be = 4'b0011 << {mem_addr_i[1], 1'b0}; w_wdata = {2{mem_wdata_i[15:0]}}; end
        default: begin w_be = 4'b1111;                          w_wdata = mem_wdata_i;            end
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((w_size == C_SZ_H) && mem_addr_i[0]) ||
                 ((w_size == C_SZ_W) && (mem_addr_i[1:0] != 2'b00));
`endif
  end

  // Right-align the acked read word according to the captured size and lane
  always_comb begin
    w_shamt = 5'd0;
    w_mask  = 32'hFFFF_FFFF;
    case (r_size)
      C_SZ_B:  begin w_shamt = {r_lane, 3'b000};       w_mask = 32'h0000_00FF; end
      C_SZ_H:  begin w_shamt = {r_lane[1], 4'b0000};   w_mask = 32'h0000_FFFF; end
      default: begin w_shamt = 5'd0;                   w_mask = 32'hFFFF_FFFF; end
    endcase
    w_load = (bus_rdata_i >> w_shamt) & w_mask;
  end

  // Next-state and handshake outputs; ack beats a simultaneous timeout
  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    bus_req_o = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = mem_req_i;
        if (mem_req_i) begin
          w_capture = 1'b1;
          w_next    = w_misalign ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (bus_ack_i) begin
          w_next = S_DONE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_next    = S_ERR;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Transaction capture, timeout counter and load-data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_lane   <= 2'b00;
      r_size   <= C_SZ_W;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
      r_rddata <= '0;
      r_mis    <= 1'b0;
    end else begin
      if (r_state == S_REQ) r_cnt <= r_cnt + 1'b1;
      else                  r_cnt <= '0;
      if (w_capture) begin
        r_we    <= w_we;
        r_waddr <= mem_addr_i[31:2];
        r_lane  <= mem_addr_i[1:0];
        r_size  <= w_size;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_mis   <= w_misalign;
        if (w_misalign) r_rddata <= '0;
      end
      if ((r_state == S_REQ) && bus_ack_i) r_rddata <= r_we ? 32'd0 : w_load;
      else if (w_timeout)                  r_rddata <= '0;
    end
  end

  assign bus_we_o    = r_we;
  assign bus_addr_o  = {r_waddr, 2'b00};
  assign bus_be_o    = r_be;
  assign bus_wdata_o = r_wdata;
  assign bus_rddata  = r_rddata;
  assign bus_err_o   = (r_state == S_ERR) && !r_mis;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o  = (r_state == S_ERR) && r_mis;
`else
  assign misalign_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ============================================================================
// Module   : tb_lsu_bus_ctrl
// Purpose  : Directed self-checking bench for lsu_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        mem_req_i;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  logic [31:0]                 mem_addr_i, mem_wdata_i;
  logic                        stall_o, bus_err_o, misalign_o, bus_req_o, bus_we_o;
  logic [31:0]                 bus_rddata, bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]                  bus_be_o;
  logic                        bus_ack_i;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          stalls, req_cycles;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  lsu_bus_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req_i(mem_req_i), .mnemonic(mnemonic),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .stall_o(stall_o),
    .bus_rddata(bus_rddata), .bus_err_o(bus_err_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Run one access; ack in REQ cycle ack_cyc (-1 = never). Returns at #1
  // after the negedge of the first non-stalled cycle, mem_req_i still high.
  task automatic txn(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc);
    stalls = 0; req_cycles = 0;
    obs_addr = 'x; obs_be = 'x; obs_wdata = 'x; obs_we = 'x;
    @(negedge clk);
    mem_req_i = 1'b1; mnemonic = mn; mem_addr_i = a; mem_wdata_i = wd;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall_o) break;
      stalls++;
      if (bus_req_o) begin
        if (req_cycles == 0) begin
          obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_we = bus_we_o;
        end
        if (req_cycles == ack_cyc) begin bus_ack_i = 1'b1; bus_rdata_i = rd; end
        req_cycles++;
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_req_i = 1'b0; mnemonic = LW; mem_addr_i = '0; mem_wdata_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, bus_req_o}, 32'd0);
    check("rst_rddata", bus_rddata, 32'd0);
    check("rst_err", {30'd0, bus_err_o, misalign_o}, 32'd0);
    check("rst_bus", {bus_addr_o[31:4], bus_be_o}, 32'd0);
    check("rst_wdata_we", bus_wdata_o | {31'd0, bus_we_o}, 32'd0);
    rst_n = 1'b1;

    // LW aligned, ack in first REQ cycle
    txn(LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_stalls", stalls, 2);
    check("lw_addr", obs_addr, 32'h100);
    check("lw_be", {28'd0, obs_be}, 32'hF);
    check("lw_we", {31'd0, obs_we}, 32'd0);
    check("lw_data", bus_rddata, 32'hDEAD_BEEF);
    check("lw_done_stall", {31'd0, stall_o}, 32'd0);
    mem_req_i = 1'b0;

    // Ack while idle must not touch the load data
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check("idle_ack_ignored", bus_rddata, 32'hDEAD_BEEF);

    // LB top byte
    txn(LB, 32'h103, 32'h0, 32'h80FF_0011, 0);
    check("lb_addr", obs_addr, 32'h100);
    check("lb_data", bus_rddata, 32'h0000_0080);
    mem_req_i = 1'b0;

    // SH upper half, ack on third REQ cycle
    txn(SH, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 2);
    check("sh_stalls", stalls, 4);
    check("sh_addr", obs_addr, 32'h200);
    check("sh_be", {28'd0, obs_be}, 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'd0, obs_we}, 32'd1);
    check("sh_rddata", bus_rddata, 32'd0);
    mem_req_i = 1'b0;

    // SB lane 1
    txn(SB, 32'h101, 32'h0000_00A5, 32'h0, 1);
    check("sb_stalls", stalls, 3);
    check("sb_be", {28'd0, obs_be}, 32'h2);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    mem_req_i = 1'b0;

    // Half loads, upper and lower lane
    txn(LHU, 32'h102, 32'h0, 32'hBEEF_1234, 0);
    check("lhu_data", bus_rddata, 32'h0000_BEEF);
    mem_req_i = 1'b0;
    txn(LH, 32'h100, 32'h0, 32'hBEEF_1234, 0);
    check("lh_data", bus_rddata, 32'h0000_1234);
    mem_req_i = 1'b0;

    // Timeout: no ack
    txn(LW, 32'h400, 32'h0, 32'h0, -1);
    check("to_stalls", stalls, 17);
    check("to_req_cycles", req_cycles, 16);
    check("to_err", {31'd0, bus_err_o}, 32'd1);
    check("to_misalign", {31'd0, misalign_o}, 32'd0);
    check("to_rddata", bus_rddata, 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk);
    #1;
    check("to_err_pulse", {31'd0, bus_err_o}, 32'd0);

    // Misaligned word
    txn(LW, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_stalls", stalls, 1);
    check("mis_req_cycles", req_cycles, 0);
    check("mis_pulse", {30'd0, misalign_o, bus_err_o}, 32'd2);
`else
    check("mis_stalls", stalls, 2);
    check("mis_addr", obs_addr, 32'h100);
    check("mis_data", bus_rddata, 32'hCAFE_F00D);
    check("mis_pulse", {30'd0, misalign_o, bus_err_o}, 32'd0);
`endif
    mem_req_i = 1'b0;

    // Reset while in REQ, then a late ack
    @(negedge clk);
    mem_req_i = 1'b1; mnemonic = LW; mem_addr_i = 32'h300;
    @(negedge clk);
    #1;
    check("rr_in_req", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
    #1;
    check("rr_req_low", {31'd0, bus_req_o}, 32'd0);
    check("rr_stall_low", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check("rr_late_ack_data", bus_rddata, 32'd0);
    check("rr_late_ack_state", {30'd0, bus_req_o, stall_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
